imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares one synchronous-read instruction memory (registered address, data valid
//  MEM_LAT cycles after the address) between the CPU fetch port and a debug/loader
//  read port. Fixed priority to fetch, with a starvation guard for debug. Tags each
//  issued read and routes the returned word to its owner. Sits between the IF stage
//  and the instruction ROM/BRAM.
// PARAMETERS
//  AW         30  word-address width
//  DW         32  instruction width
//  MEM_LAT    1   cycles from issued address to valid mem_inst (>=1)
//  STARVE_MAX 4   consecutive denied dbg cycles before dbg wins; 0 = pure fixed priority
// PORTS
//  clk            in   1   clock; all state on posedge
//  rst_n          in   1   synchronous reset, active-low
//  fetch_valid    in   1   fetch read request
//  fetch_addr     in   AW  fetch word address
//  fetch_ready    out  1   fetch request accepted this cycle
//  fetch_rsp_vld  out  1   fetch_rsp_data valid (one-cycle pulse)
//  fetch_rsp_data out  DW  returned instruction word
//  dbg_valid      in   1   debug read request
//  dbg_addr       in   AW  debug word address
//  dbg_ready      out  1   debug request accepted this cycle
//  dbg_rsp_vld    out  1   dbg_rsp_data valid (one-cycle pulse)
//  dbg_rsp_data   out  DW  returned word
//  mem_addr       out  AW  address to memory (memory registers it)
//  mem_inst       in   DW  memory read data
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): in-flight tag pipe cleared, starve_cnt=0,
//    addr_hold=0. While rst_n=0: *_ready=0, *_rsp_vld=0, mem_addr=0. Reads issued
//    before reset never produce a response.
//  - At most one grant per cycle; ready is combinational from valid/priority.
//  - Grant: dbg if dbg_valid & (!fetch_valid | (STARVE_MAX!=0 & starve_cnt>=STARVE_MAX)),
//    else fetch if fetch_valid; otherwise no grant.
//  - mem_addr = granted address; with no grant, mem_addr = addr_hold (last granted
//    address), so memory output stays stable. addr_hold updates on every grant.
//  - starve_cnt: +1 per cycle with dbg_valid & !dbg_ready (saturates at STARVE_MAX);
//    cleared on dbg grant or dbg_valid=0.
//  - Tag pipe, MEM_LAT deep, entries {vld, owner}: a grant pushes {1, owner}; a
//    cycle without a grant pushes {0, x}. Exiting entry with vld=1 asserts the
//    owner's rsp_vld for one cycle with rsp_data = mem_inst; other rsp_vld = 0.
//  - Fully pipelined: back-to-back grants every cycle, responses in grant order.
//  - rsp_data of each port holds its last returned word when rsp_vld=0.
//  - No response backpressure; requesters accept rsp_vld unconditionally.
//  - Requester must hold valid/addr stable until ready (not checked).
// CONFIGURATION
//  IMEM_ARB_STATS_EN defined: extra outputs stat_fetch_grants[31:0],
//   stat_dbg_grants[31:0], stat_conflicts[31:0] (cycles with both valid). Counters
//   clear on reset and wrap mod 2^32.
//  Not defined: these ports and counters are absent; no other behaviour changes.
// TESTING
//  1 Reset: rst_n=0 3 cycles with fetch_valid=1 -> ready=0, rsp_vld=0, mem_addr=0.
//  2 Fetch stream: addr 0..5 every cycle, MEM_LAT=1 -> fetch_rsp_vld from cycle+1,
//    data = ROM[0..5] in order, no gaps.
//  3 Starvation: both valid, STARVE_MAX=4 -> 4 fetch grants, dbg grant on 5th
//    cycle, starve_cnt back to 0, fetch resumes next cycle.
//  4 Idle hold: grant addr 0x2A then no requests 5 cycles -> mem_addr stays 0x2A,
//    no rsp_vld.
//  5 Reset mid-flight: fetch grant at addr 3, rst_n=0 next cycle -> no fetch_rsp_vld
//    for addr 3.
//  6 STATS_EN: 10 fetch, 3 dbg, 2 conflict cycles -> counters 10/3/2.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Request/response port shared by the fetch and debug requesters of imem_arbiter.
// master = requester side, slave = arbiter side.
interface imem_arbiter_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic          valid;
  logic [AW-1:0] addr;
  logic          ready;
  logic          rsp_vld;
  logic [DW-1:0] rsp_data;

  modport master (
    output valid,
    output addr,
    input  ready,
    input  rsp_vld,
    input  rsp_data
  );

  modport slave (
    input  valid,
    input  addr,
    output ready,
    output rsp_vld,
    output rsp_data
  );
endinterface

// File: rtl/imem_arbiter.sv
// Fetch/debug arbiter in front of a synchronous-read instruction memory.
// Define IMEM_ARB_STATS_EN to add grant/conflict statistics counters.
module imem_arbiter #(
  parameter int AW         = 30,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_arbiter_if.slave fetch,
  imem_arbiter_if.slave dbg,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_inst
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_fetch_grants,
  output logic [31:0]   stat_dbg_grants,
  output logic [31:0]   stat_conflicts
`endif
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0]      starve_cnt;
  logic [AW-1:0]      addr_hold;
  logic [MEM_LAT-1:0] tag_vld;
  logic [MEM_LAT-1:0] tag_dbg;
  logic [DW-1:0]      fetch_last;
  logic [DW-1:0]      dbg_last;

  logic starve_hit;
  logic dbg_gnt;
  logic fetch_gnt;
  logic fetch_out;
  logic dbg_out;

  assign starve_hit = (STARVE_MAX != 0) &&
                      (starve_cnt >= SW'(STARVE_MAX));

  assign dbg_gnt   = rst_n & dbg.valid &
                     (~fetch.valid | starve_hit);
  assign fetch_gnt = rst_n & fetch.valid & ~dbg_gnt;

  assign fetch.ready = fetch_gnt;
  assign dbg.ready   = dbg_gnt;

  always_comb begin
    mem_addr = addr_hold;
    if (!rst_n)
      mem_addr = '0;
    else if (dbg_gnt)
      mem_addr = dbg.addr;
    else if (fetch_gnt)
      mem_addr = fetch.addr;
  end

  // Exit slot of the tag pipe lines up with mem_inst for that grant.
  assign fetch_out = rst_n & tag_vld[MEM_LAT-1] & ~tag_dbg[MEM_LAT-1];
  assign dbg_out   = rst_n & tag_vld[MEM_LAT-1] &  tag_dbg[MEM_LAT-1];

  assign fetch.rsp_vld  = fetch_out;
  assign dbg.rsp_vld    = dbg_out;
  assign fetch.rsp_data = fetch_out ? mem_inst : fetch_last;
  assign dbg.rsp_data   = dbg_out   ? mem_inst : dbg_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      addr_hold  <= '0;
      tag_vld    <= '0;
      tag_dbg    <= '0;
      fetch_last <= '0;
      dbg_last   <= '0;
    end else begin
      if (!dbg.valid || dbg_gnt)
        starve_cnt <= '0;
      else if (starve_cnt < SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);
      if (dbg_gnt || fetch_gnt)
        addr_hold <= mem_addr;
      tag_vld[0] <= dbg_gnt | fetch_gnt;
      tag_dbg[0] <= dbg_gnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_dbg[i] <= tag_dbg[i-1];
      end
      if (fetch_out)
        fetch_last <= mem_inst;
      if (dbg_out)
        dbg_last <= mem_inst;
    end
  end

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_fetch_grants <= '0;
      stat_dbg_grants   <= '0;
      stat_conflicts    <= '0;
    end else begin
      if (fetch_gnt)
        stat_fetch_grants <= stat_fetch_grants + 32'd1;
      if (dbg_gnt)
        stat_dbg_grants <= stat_dbg_grants + 32'd1;
      if (fetch.valid && dbg.valid)
        stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: queue-based model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_imem_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_arbiter_if #(.AW(AW), .DW(DW)) fetch_if ();
  imem_arbiter_if #(.AW(AW), .DW(DW)) dbg_if ();

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_inst = '0;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0] st_f, st_d, st_c;
`endif

  imem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch    (fetch_if),
    .dbg      (dbg_if),
    .mem_addr (mem_addr),
    .mem_inst (mem_inst)
`ifdef IMEM_ARB_STATS_EN
    ,
    .stat_fetch_grants (st_f),
    .stat_dbg_grants   (st_d),
    .stat_conflicts    (st_c)
`endif
  );

  function automatic logic [31:0] rom(logic [AW-1:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Memory with a one-cycle registered address.
  always @(posedge clk) mem_inst <= rom(mem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int            due;
    bit            is_dbg;
    logic [AW-1:0] a;
  } rd_t;

  rd_t           pend[$];
  rd_t           r;
  int            cyc = 0;
  int            starve = 0;
  logic [AW-1:0] hold = '0;
  logic [31:0]   flast, dlast;
  bit            fknown = 0, dknown = 0;
  bit            eg_d, eg_f, ef, ed;
  logic [AW-1:0] ea;
  int unsigned   mf = 0, md = 0, mc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_fready", fetch_if.ready, 0);
      check("rst_dready", dbg_if.ready, 0);
      check("rst_frsp", fetch_if.rsp_vld, 0);
      check("rst_drsp", dbg_if.rsp_vld, 0);
      check("rst_maddr", mem_addr, 0);
      pend.delete();
      starve = 0;
      hold = '0;
      fknown = 0;
      dknown = 0;
      mf = 0; md = 0; mc = 0;
    end else begin
      eg_d = dbg_if.valid && (!fetch_if.valid || starve >= SMAX);
      eg_f = fetch_if.valid && !eg_d;
      ea = eg_d ? dbg_if.addr : (eg_f ? fetch_if.addr : hold);
      ef = 0;
      ed = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.is_dbg) begin
          ed = 1; dlast = rom(r.a); dknown = 1;
        end else begin
          ef = 1; flast = rom(r.a); fknown = 1;
        end
      end
      check("m_fready", fetch_if.ready, eg_f);
      check("m_dready", dbg_if.ready, eg_d);
      check("m_maddr", mem_addr, ea);
      check("m_frsp", fetch_if.rsp_vld, ef);
      check("m_drsp", dbg_if.rsp_vld, ed);
      if (fknown) check("m_fdata", fetch_if.rsp_data, flast);
      if (dknown) check("m_ddata", dbg_if.rsp_data, dlast);
`ifdef IMEM_ARB_STATS_EN
      check("m_stf", st_f, mf);
      check("m_std", st_d, md);
      check("m_stc", st_c, mc);
`endif
      if (eg_d || eg_f) pend.push_back('{cyc + 1, eg_d, ea});
      hold = ea;
      if (!dbg_if.valid || eg_d) starve = 0;
      else if (starve < SMAX) starve++;
      mf += eg_f;
      md += eg_d;
      mc += (fetch_if.valid && dbg_if.valid);
    end
  end

  // Apply inputs just after posedge, return mid-way to the negedge.
  task automatic drive(bit rs, bit fv, logic [AW-1:0] fa,
                       bit dv, logic [AW-1:0] da);
    @(posedge clk);
    #1;
    rst_n = rs;
    fetch_if.valid = fv;
    fetch_if.addr = fa;
    dbg_if.valid = dv;
    dbg_if.addr = da;
    #2;
  endtask

  bit exp_dr[6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    fetch_if.valid = 0; fetch_if.addr = '0;
    dbg_if.valid = 0; dbg_if.addr = '0;

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 30'h11, 0, '0);
      check("t1_fready", fetch_if.ready, 0);
      check("t1_frsp", fetch_if.rsp_vld, 0);
      check("t1_maddr", mem_addr, 0);
    end

    for (int k = 0; k < 6; k++) begin
      drive(1, 1, AW'(k), 0, '0);
      check("t2_fready", fetch_if.ready, 1);
      if (k > 0) begin
        check("t2_frsp", fetch_if.rsp_vld, 1);
        check("t2_fdata", fetch_if.rsp_data, 32'hC0DE_0000 + k - 1);
      end
    end
    drive(1, 0, '0, 0, '0);
    check("t2_last_vld", fetch_if.rsp_vld, 1);
    check("t2_last_data", fetch_if.rsp_data, 32'hC0DE_0005);

    for (int i = 0; i < 6; i++) begin
      drive(1, 1, AW'(10 + (i < 4 ? i : 4)), i < 5, 30'h100);
      check("t3_dready", dbg_if.ready, exp_dr[i]);
      check("t3_fready", fetch_if.ready, !exp_dr[i]);
    end
    check("t3_drsp", dbg_if.rsp_vld, 1);
    check("t3_ddata", dbg_if.rsp_data, 32'hC0DE_0100);
    drive(1, 1, 30'h20, 1, 30'h101);
    check("t3_cnt_clr", fetch_if.ready, 1);
    drive(1, 0, '0, 1, 30'h101);
    check("t3_dbg_alone", dbg_if.ready, 1);

    drive(1, 1, 30'h2A, 0, '0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, '0, 0, '0);
      check("t4_maddr", mem_addr, 30'h2A);
      check("t4_frsp", fetch_if.rsp_vld, i == 0);
      check("t4_drsp", dbg_if.rsp_vld, 0);
    end
    check("t4_fdata", fetch_if.rsp_data, 32'hC0DE_002A);

    drive(1, 1, 30'h3, 0, '0);
    drive(0, 0, '0, 0, '0);
    check("t5_rst_rsp", fetch_if.rsp_vld, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, '0, 0, '0);
      check("t5_no_rsp", fetch_if.rsp_vld, 0);
    end

`ifdef IMEM_ARB_STATS_EN
    drive(0, 0, '0, 0, '0);
    for (int i = 0; i < 8; i++) drive(1, 1, AW'(i), 0, '0);
    for (int i = 0; i < 2; i++) drive(1, 1, AW'(8 + i), 1, 30'h77);
    for (int i = 0; i < 3; i++) drive(1, 0, '0, 1, AW'(30'h77 + i));
    drive(1, 0, '0, 0, '0);
    check("t6_fetch_grants", st_f, 10);
    check("t6_dbg_grants", st_d, 3);
    check("t6_conflicts", st_c, 2);
`endif

    drive(1, 0, '0, 0, '0);
    drive(1, 0, '0, 0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
